// File: rtl/n64_pi_pkg.sv
// Shared constants, fetch-state encoding and window decode for the N64 PI cart front end.
package n64_pi_pkg;

    localparam logic [31:0] ROM_BASE_DEFAULT      = 32'h1000_0000;
    localparam int          ROM_SIZE_LOG2_DEFAULT = 25;
    localparam int          SYNC_STAGES_DEFAULT   = 2;
    localparam int          PI_HW_WIDTH           = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } fetch_state_t;

    // True when the full PI address falls inside the aligned ROM window at base.
    function automatic logic window_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int          size_log2);
        logic [31:0] mask_s;
        mask_s = ~((32'd1 << size_log2) - 32'd1);
        return (addr & mask_s) == base;
    endfunction

endpackage

// File: rtl/n64_pi_input_sync.sv
// Synchronizer chain for the asynchronous PI inputs plus edge detection on the
// synchronized strobes; AD16 is delayed by the same depth so it stays aligned.
module n64_pi_input_sync
    import n64_pi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PI_HW_WIDTH-1:0] ad_in,
    input  logic                   ale_h,
    input  logic                   ale_l,
    input  logic                   read_n,
    input  logic                   write_n,
    output logic [PI_HW_WIDTH-1:0] ad_sync,
    output logic                   ale_h_fall,
    output logic                   ale_l_fall,
    output logic                   read_fall,
    output logic                   read_rise,
    output logic                   write_rise
);

    // Bit order {write_n, read_n, ale_l, ale_h}; strobes idle high so reset creates no edge.
    localparam logic [3:0] CTL_IDLE = 4'b1100;

    logic [3:0]             ctl_pipe_r [SYNC_STAGES];
    logic [PI_HW_WIDTH-1:0] ad_pipe_r  [SYNC_STAGES];
    logic [3:0]             ctl_prev_r;
    logic [3:0]             ctl_s;

    // Shift inputs through the synchronizer and remember the last synchronized control value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ctl_pipe_r[i] <= CTL_IDLE;
                ad_pipe_r[i]  <= {PI_HW_WIDTH{1'b0}};
            end
            ctl_prev_r <= CTL_IDLE;
        end else begin
            ctl_pipe_r[0] <= {write_n, read_n, ale_l, ale_h};
            ad_pipe_r[0]  <= ad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ctl_pipe_r[i] <= ctl_pipe_r[i-1];
                ad_pipe_r[i]  <= ad_pipe_r[i-1];
            end
            ctl_prev_r <= ctl_s;
        end
    end

    assign ctl_s      = ctl_pipe_r[SYNC_STAGES-1];
    assign ad_sync    = ad_pipe_r[SYNC_STAGES-1];
    assign ale_h_fall = ctl_prev_r[0] & ~ctl_s[0];
    assign ale_l_fall = ctl_prev_r[1] & ~ctl_s[1];
    assign read_fall  = ctl_prev_r[2] & ~ctl_s[2];
    assign read_rise  = ~ctl_prev_r[2] & ctl_s[2];
    assign write_rise = ~ctl_prev_r[3] & ctl_s[3];

endmodule

// File: rtl/n64_pi_read_frontend.sv
// N64 PI cart ROM front end: address decode, one-word SDRAM prefetch, AD16 drive.
// Optional cart writes are enabled by defining N64_WRITE_EN.
module n64_pi_read_frontend
    import n64_pi_pkg::*;
#(
    parameter logic [31:0] ROM_BASE      = ROM_BASE_DEFAULT,
    parameter int          ROM_SIZE_LOG2 = ROM_SIZE_LOG2_DEFAULT,
    parameter int          SYNC_STAGES   = SYNC_STAGES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PI_HW_WIDTH-1:0] n64_ad_in,
    output logic [PI_HW_WIDTH-1:0] n64_ad_out,
    output logic                   n64_ad_oe,
    input  logic                   n64_ale_h,
    input  logic                   n64_ale_l,
    input  logic                   n64_read_n,
    input  logic                   n64_write_n,
    output logic                   readport_rd,
    output logic [31:0]            readport_addr,
    input  logic [PI_HW_WIDTH-1:0] readport_data,
    input  logic                   readport_ack,
    output logic                   writeport_wr,
    output logic [31:0]            writeport_addr,
    output logic [PI_HW_WIDTH-1:0] writeport_data,
    input  logic                   writeport_ack,
    output logic                   underrun_err
);

    localparam int               OFF_W    = ROM_SIZE_LOG2;
    localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(32'd2);

    logic [PI_HW_WIDTH-1:0] ad_sync_s;
    logic                   ale_h_fall_s;
    logic                   ale_l_fall_s;
    logic                   read_fall_s;
    logic                   read_rise_s;
    logic                   write_rise_s;
    logic [31:0]            ale_addr_s;
    logic                   wr_idle_s;
    logic                   wr_take_s;

    logic [PI_HW_WIDTH-1:0] addr_hi_r;
    logic                   hit_r;
    logic [OFF_W-1:0]       cur_off_r;
    logic [PI_HW_WIDTH-1:0] buf_r;
    logic                   buf_valid_r;
    logic                   fetch_pend_r;
    logic                   stale_r;
    fetch_state_t           rd_state_r;

    n64_pi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .ad_in      (n64_ad_in),
        .ale_h      (n64_ale_h),
        .ale_l      (n64_ale_l),
        .read_n     (n64_read_n),
        .write_n    (n64_write_n),
        .ad_sync    (ad_sync_s),
        .ale_h_fall (ale_h_fall_s),
        .ale_l_fall (ale_l_fall_s),
        .read_fall  (read_fall_s),
        .read_rise  (read_rise_s),
        .write_rise (write_rise_s)
    );

    assign ale_addr_s = {addr_hi_r, ad_sync_s};

`ifdef N64_WRITE_EN
    fetch_state_t wr_state_r;
    logic         wr_pend_r;

    assign wr_idle_s = !wr_pend_r && (wr_state_r == ST_IDLE);
    assign wr_take_s = write_rise_s && hit_r && !ale_l_fall_s;
`else
    logic unused_s;

    assign wr_idle_s      = 1'b1;
    assign wr_take_s      = 1'b0;
    assign writeport_wr   = 1'b0;
    assign writeport_addr = 32'd0;
    assign writeport_data = {PI_HW_WIDTH{1'b0}};
    assign unused_s       = ^{writeport_ack, write_rise_s};
`endif

    // Fetch FSM, PI strobe service and address capture; later statements take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n64_ad_out    <= {PI_HW_WIDTH{1'b0}};
            n64_ad_oe     <= 1'b0;
            readport_rd   <= 1'b0;
            readport_addr <= 32'd0;
            underrun_err  <= 1'b0;
            addr_hi_r     <= {PI_HW_WIDTH{1'b0}};
            hit_r         <= 1'b0;
            cur_off_r     <= {OFF_W{1'b0}};
            buf_r         <= {PI_HW_WIDTH{1'b0}};
            buf_valid_r   <= 1'b0;
            fetch_pend_r  <= 1'b0;
            stale_r       <= 1'b0;
            rd_state_r    <= ST_IDLE;
`ifdef N64_WRITE_EN
            writeport_wr   <= 1'b0;
            writeport_addr <= 32'd0;
            writeport_data <= {PI_HW_WIDTH{1'b0}};
            wr_state_r     <= ST_IDLE;
            wr_pend_r      <= 1'b0;
`endif
        end else begin
            case (rd_state_r)
                ST_IDLE: begin
                    // Never launch against an address that is being replaced this cycle.
                    if (fetch_pend_r && !buf_valid_r && !readport_ack && !ale_l_fall_s
                        && wr_idle_s && !wr_take_s) begin
                        readport_rd   <= 1'b1;
                        readport_addr <= {{(32-OFF_W){1'b0}}, cur_off_r};
                        fetch_pend_r  <= 1'b0;
                        stale_r       <= 1'b0;
                        rd_state_r    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (readport_ack) begin
                        buf_r <= readport_data;
                        if (!stale_r && !ale_l_fall_s && !wr_take_s) begin
                            buf_valid_r <= 1'b1;
                        end
                        readport_rd <= 1'b0;
                        rd_state_r  <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!readport_ack) begin
                        rd_state_r <= ST_IDLE;
                    end
                end
                default: rd_state_r <= ST_IDLE;
            endcase

`ifdef N64_WRITE_EN
            // Writes start only once the read side is idle.
            case (wr_state_r)
                ST_IDLE: begin
                    if (wr_pend_r && (rd_state_r == ST_IDLE) && !writeport_ack) begin
                        writeport_wr <= 1'b1;
                        wr_pend_r    <= 1'b0;
                        wr_state_r   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (writeport_ack) begin
                        writeport_wr <= 1'b0;
                        wr_state_r   <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!writeport_ack) begin
                        wr_state_r <= ST_IDLE;
                    end
                end
                default: wr_state_r <= ST_IDLE;
            endcase
`endif

            if (read_fall_s && hit_r && !ale_l_fall_s) begin
                n64_ad_oe  <= 1'b1;
                n64_ad_out <= buf_r;
                if (buf_valid_r) begin
                    buf_valid_r  <= 1'b0;
                    cur_off_r    <= cur_off_r + OFF_STEP;
                    fetch_pend_r <= 1'b1;
                end else begin
                    underrun_err <= 1'b1;
                end
            end else if (read_rise_s) begin
                n64_ad_oe <= 1'b0;
            end

`ifdef N64_WRITE_EN
            if (wr_take_s) begin
                if (!wr_idle_s) begin
                    underrun_err <= 1'b1;
                end else begin
                    wr_pend_r      <= 1'b1;
                    writeport_addr <= {{(32-OFF_W){1'b0}}, cur_off_r};
                    writeport_data <= ad_sync_s;
                    cur_off_r      <= cur_off_r + OFF_STEP;
                    buf_valid_r    <= 1'b0;
                    fetch_pend_r   <= 1'b1;
                    if (rd_state_r != ST_IDLE) begin
                        stale_r <= 1'b1;
                    end
                end
            end
`endif

            if (ale_h_fall_s) begin
                addr_hi_r <= ad_sync_s;
            end
            if (ale_l_fall_s) begin
                hit_r        <= window_hit(ale_addr_s, ROM_BASE, ROM_SIZE_LOG2);
                cur_off_r    <= {ale_addr_s[OFF_W-1:1], 1'b0};
                fetch_pend_r <= window_hit(ale_addr_s, ROM_BASE, ROM_SIZE_LOG2);
                buf_valid_r  <= 1'b0;
                if (rd_state_r != ST_IDLE) begin
                    stale_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_n64_pi_read_frontend.sv
// Scoreboard bench for n64_pi_read_frontend: stimulus pushes expected fetch
// addresses and AD values, monitors pop and compare as the DUT presents them.
module tb_n64_pi_read_frontend;

    localparam int SYNC = 2;

    typedef struct packed {
        logic        chk;
        logic [15:0] val;
    } ad_exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] n64_ad_in;
    logic [15:0] n64_ad_out;
    logic        n64_ad_oe;
    logic        n64_ale_h;
    logic        n64_ale_l;
    logic        n64_read_n;
    logic        n64_write_n;
    logic        readport_rd;
    logic [31:0] readport_addr;
    logic [15:0] readport_data;
    logic        readport_ack;
    logic        writeport_wr;
    logic [31:0] writeport_addr;
    logic [15:0] writeport_data;
    logic        writeport_ack;
    logic        underrun_err;

    n64_pi_read_frontend dut (
        .clk            (clk),
        .rst            (rst),
        .n64_ad_in      (n64_ad_in),
        .n64_ad_out     (n64_ad_out),
        .n64_ad_oe      (n64_ad_oe),
        .n64_ale_h      (n64_ale_h),
        .n64_ale_l      (n64_ale_l),
        .n64_read_n     (n64_read_n),
        .n64_write_n    (n64_write_n),
        .readport_rd    (readport_rd),
        .readport_addr  (readport_addr),
        .readport_data  (readport_data),
        .readport_ack   (readport_ack),
        .writeport_wr   (writeport_wr),
        .writeport_addr (writeport_addr),
        .writeport_data (writeport_data),
        .writeport_ack  (writeport_ack),
        .underrun_err   (underrun_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_req_q [$];
    ad_exp_t     ad_q      [$];
    wr_exp_t     wr_q      [$];

    logic [15:0] sdram_wr [int];
    logic [15:0] model_wr [int];

    logic [31:0] model_off = 32'd0;
    bit          model_hit = 1'b0;
    int          ack_delay = 12;
    int          rd_rises  = 0;
    int          oe_rises  = 0;

    function automatic logic [15:0] base_val(input logic [31:0] a);
        return {a[8:1], a[16:9]} ^ 16'hC35A ^ {a[24:17], 8'h00};
    endfunction

    function automatic logic [15:0] sdram_rd(input logic [31:0] a);
        if (sdram_wr.exists(int'(a))) return sdram_wr[int'(a)];
        return base_val(a);
    endfunction

    function automatic logic [15:0] model_rd(input logic [31:0] a);
        if (model_wr.exists(int'(a))) return model_wr[int'(a)];
        return base_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SDRAM controller model: acks ack_delay cycles after a request, drops ack after rd/wr drops.
    initial begin
        int rcnt = 0;
        int wcnt = 0;
        readport_ack  = 1'b0;
        readport_data = 16'h0000;
        writeport_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                readport_ack  = 1'b0;
                writeport_ack = 1'b0;
                rcnt = 0;
                wcnt = 0;
            end else begin
                if (readport_rd && !readport_ack) begin
                    rcnt++;
                    if (rcnt >= ack_delay) begin
                        readport_data = sdram_rd(readport_addr);
                        readport_ack  = 1'b1;
                        rcnt = 0;
                    end
                end else if (!readport_rd) begin
                    readport_ack = 1'b0;
                end
                if (writeport_wr && !writeport_ack) begin
                    wcnt++;
                    if (wcnt >= ack_delay) begin
                        sdram_wr[int'(writeport_addr)] = writeport_data;
                        writeport_ack = 1'b1;
                        wcnt = 0;
                    end
                end else if (!writeport_wr) begin
                    writeport_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: fetch addresses, AD data on each oe rise, write requests, handshake rules.
    initial begin
        logic prev_rd = 1'b0, prev_oe = 1'b0, prev_wr = 1'b0;
        logic racked = 1'b0, wacked = 1'b0;
        ad_exp_t e;
        wr_exp_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0; prev_oe = 1'b0; prev_wr = 1'b0;
                racked  = 1'b0; wacked  = 1'b0;
            end else begin
                if (readport_rd && !prev_rd) begin
                    rd_rises++;
                    check("rd_rise_ack_low", readport_ack, 1'b0);
                    if (exp_req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rd_unexpected actual=%h required=none", readport_addr);
                    end else begin
                        check("rd_addr", readport_addr, exp_req_q.pop_front());
                    end
                end
                if (readport_rd && readport_ack) racked = 1'b1;
                if (!readport_rd && prev_rd) begin
                    check("rd_held_until_ack", racked, 1'b1);
                    racked = 1'b0;
                end
                if (n64_ad_oe && !prev_oe) begin
                    oe_rises++;
                    if (ad_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL oe_unexpected actual=%h required=none", n64_ad_out);
                    end else begin
                        e = ad_q.pop_front();
                        if (e.chk) check("ad_data", n64_ad_out, e.val);
                    end
                end
                if (writeport_wr && !prev_wr) begin
                    if (wr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL wr_unexpected actual=%h required=none", writeport_addr);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", writeport_addr, w.a);
                        check("wr_data", writeport_data, w.d);
                    end
                end
                if (writeport_wr && writeport_ack) wacked = 1'b1;
                if (!writeport_wr && prev_wr) begin
                    check("wr_held_until_ack", wacked, 1'b1);
                    wacked = 1'b0;
                end
                prev_rd = readport_rd;
                prev_oe = n64_ad_oe;
                prev_wr = writeport_wr;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_ale(input logic [31:0] a, input bit chk_lat);
        int lat;
        n64_ad_in = a[31:16];
        n64_ale_h = 1'b1;
        n64_ale_l = 1'b1;
        cycles(4);
        n64_ale_h = 1'b0;
        cycles(4);
        n64_ad_in = a[15:0];
        cycles(4);
        model_hit = ((a >> 25) == (32'h1000_0000 >> 25));
        if (model_hit) begin
            model_off = a & 32'h01FF_FFFE;
            exp_req_q.push_back(model_off);
        end
        n64_ale_l = 1'b0;
        if (chk_lat) begin
            lat = 0;
            for (int i = 1; i <= 10 && lat == 0; i++) begin
                @(negedge clk);
                if (readport_rd) lat = i;
            end
            check("ale_to_rd_latency", lat, SYNC + 2);
        end
    endtask

    task automatic strobe(input bit data_ready);
        if (model_hit) begin
            if (data_ready) begin
                ad_q.push_back('{1'b1, model_rd(model_off)});
                model_off = (model_off + 32'd2) & 32'h01FF_FFFF;
                exp_req_q.push_back(model_off);
            end else begin
                ad_q.push_back('{1'b0, 16'h0000});
            end
        end
        n64_read_n = 1'b0;
        cycles(8);
        n64_read_n = 1'b1;
        cycles(4);
    endtask

    task automatic do_write(input logic [15:0] d);
        wr_q.push_back('{model_off, d});
        model_wr[int'(model_off)] = d;
        model_off = (model_off + 32'd2) & 32'h01FF_FFFF;
        exp_req_q.push_back(model_off);
        n64_ad_in   = d;
        n64_write_n = 1'b0;
        cycles(6);
        n64_write_n = 1'b1;
        cycles(4);
    endtask

    initial begin
        int r0, o0, n;
        logic [31:0] ra;
        rst         = 1'b1;
        n64_ad_in   = 16'h0000;
        n64_ale_h   = 1'b0;
        n64_ale_l   = 1'b0;
        n64_read_n  = 1'b1;
        n64_write_n = 1'b1;
        cycles(3);
        check("rst_ad_out", n64_ad_out, 16'h0000);
        check("rst_oe", n64_ad_oe, 1'b0);
        check("rst_rd", readport_rd, 1'b0);
        check("rst_rd_addr", readport_addr, 32'd0);
        check("rst_underrun", underrun_err, 1'b0);
        check("rst_wr", writeport_wr, 1'b0);
        rst = 1'b0;
        cycles(5);

        // Sequential burst from 0x100 with 12-cycle acks, strobes 40 cycles apart.
        ack_delay = 12;
        do_ale(32'h1000_0100, 1'b1);
        cycles(30);
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
            cycles(28);
        end
        check("burst_no_underrun", underrun_err, 1'b0);

        // Access outside the window: no fetch, no drive.
        r0 = rd_rises;
        o0 = oe_rises;
        do_ale(32'h0500_0000, 1'b0);
        cycles(20);
        strobe(1'b0);
        strobe(1'b0);
        cycles(20);
        check("miss_rd_count", rd_rises - r0, 0);
        check("miss_oe_count", oe_rises - o0, 0);

        // Offset wraps at the top of the window.
        do_ale(32'h11FF_FFFE, 1'b0);
        cycles(30);
        strobe(1'b1);
        cycles(30);
        strobe(1'b1);
        cycles(30);

        // New address while a fetch is outstanding: stale word discarded.
        ack_delay = 40;
        do_ale(32'h1000_1000, 1'b0);
        cycles(8);
        check("stale_rd_in_flight", readport_rd, 1'b1);
        do_ale(32'h1000_2000, 1'b0);
        cycles(100);
        strobe(1'b1);
        cycles(60);

        // Randomized bursts with random controller latency.
        for (int b = 0; b < 3; b++) begin
            ack_delay = $urandom_range(1, 20);
            ra = 32'h1000_0000 | ($urandom() & 32'h01FF_FFFE);
            do_ale(ra, 1'b0);
            cycles(40);
            n = $urandom_range(2, 4);
            for (int s = 0; s < n; s++) begin
                strobe(1'b1);
                cycles(30);
            end
        end
        check("random_no_underrun", underrun_err, 1'b0);

`ifdef N64_WRITE_EN
        // Write 0xBEEF at 0x40, then read it back through a fresh address phase.
        ack_delay = 12;
        do_ale(32'h1000_0040, 1'b0);
        cycles(30);
        do_write(16'hBEEF);
        cycles(60);
        check("wr_released", writeport_wr, 1'b0);
        do_ale(32'h1000_0040, 1'b0);
        cycles(30);
        strobe(1'b1);
        cycles(30);
        check("write_no_underrun", underrun_err, 1'b0);
`else
        check("wr_tied_off", writeport_wr, 1'b0);
        check("wr_addr_tied_off", writeport_addr, 32'd0);
        check("wr_data_tied_off", writeport_data, 16'h0000);
`endif

        // Starved strobe: underrun flag, oe still asserted; reset clears the flag.
        ack_delay = 200;
        do_ale(32'h1000_3000, 1'b0);
        cycles(30);
        ad_q.push_back('{1'b0, 16'h0000});
        n64_read_n = 1'b0;
        cycles(SYNC + 2);
        check("underrun_oe", n64_ad_oe, 1'b1);
        check("underrun_flag", underrun_err, 1'b1);
        n64_read_n = 1'b1;
        cycles(SYNC + 2);
        check("strobe_end_oe", n64_ad_oe, 1'b0);
        rst = 1'b1;
        cycles(2);
        check("reset_clears_underrun", underrun_err, 1'b0);
        check("reset_drops_rd", readport_rd, 1'b0);
        rst = 1'b0;
        model_hit = 1'b0;
        ack_delay = 12;
        cycles(20);

        check("req_queue_drained", exp_req_q.size(), 0);
        check("ad_queue_drained", ad_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
